// File: rtl/trap_csr_unit.sv
// -----------------------------------------------------------------------------
// trap_csr_unit
//   Machine-mode trap controller. Consumes the exception verifier's
//   {exception, interrup, excep_info} bundle and owns the trap CSRs
//   (mstatus, mtvec, mepc, mcause, mip, mtrapcnt). A taken trap squashes the
//   in-flight instruction for one cycle, then redirects fetch to mtvec. mret
//   restores mstatus and redirects fetch to mepc.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   exception         verifier: exception detected this cycle
//   interrup          verifier: interrupt request this cycle
//   excep_info[31:0]  [31] cause_type, [30:24] cause code,
//                     [23:16] new mstatus, [15:0] faulting PC
//   mret_instr        decoder: mret executing (1-cycle pulse)
//   csr_we, csr_addr, csr_wdata   CSR write port (csrrw)
//   csr_rdata         combinational read of csr_addr, 0 when unmapped
//   flush             squash the in-flight instruction (SAVE cycle)
//   redirect_valid/redirect_ready/pc_target   fetch redirect handshake
//   mstatus, mip      fed back to the verifier
//   busy              FSM is not idle
//   dbg_state         FSM state (0 IDLE, 1 SAVE, 2 ENTER, 3 HANDLER, 4 RETURN)
//
// Redirect handshake: redirect_valid and pc_target are held stable from the
// first cycle redirect_valid is high until the cycle redirect_ready is high;
// the transfer completes in that cycle and redirect_valid drops afterwards.
// -----------------------------------------------------------------------------
module trap_csr_unit #(
   parameter logic [31:0] MSTATUS_RESET = 32'h0000_0001,
   parameter logic [31:0] MTVEC_RESET   = 32'h0000_0100,
   parameter logic [31:0] MIP_RESET     = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        exception,
   input  logic        interrup,
   input  logic [31:0] excep_info,
   input  logic        mret_instr,
   input  logic        csr_we,
   input  logic [11:0] csr_addr,
   input  logic [31:0] csr_wdata,
   output logic [31:0] csr_rdata,
   output logic        flush,
   output logic        redirect_valid,
   input  logic        redirect_ready,
   output logic [15:0] pc_target,
   output logic [31:0] mstatus,
   output logic [31:0] mip,
   output logic        busy,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SAVE    = 3'd1,
      S_ENTER   = 3'd2,
      S_HANDLER = 3'd3,
      S_RETURN  = 3'd4
   } state_t;

   localparam logic [11:0] A_MSTATUS  = 12'h300;
   localparam logic [11:0] A_MTVEC    = 12'h305;
   localparam logic [11:0] A_MEPC     = 12'h341;
   localparam logic [11:0] A_MCAUSE   = 12'h342;
   localparam logic [11:0] A_MIP      = 12'h344;
   localparam logic [11:0] A_MTRAPCNT = 12'h7C0;

   state_t      state_q;
   logic [31:0] info_q;          // [31] holds the resolved cause_type
   logic [31:0] mstatus_q;
   logic [31:0] prev_mstatus_q;
   logic [31:0] mtvec_q;
   logic [15:0] mepc_q;
   logic [31:0] mcause_q;
   logic [31:0] mip_q;
   logic [15:0] mtrapcnt_q;
   logic [15:0] mtrapcnt_d;
   logic [15:0] pc_target_q;
   logic        flush_q;
   logic        redirect_valid_q;
   logic        trap_take;

   // Interrupts are masked unless mstatus is exactly 1 and mip[0] is pending.
   assign trap_take = exception | (interrup & (mstatus_q == 32'h1) & mip_q[0]);

   // Trap counter advances once per SAVE cycle and saturates.
   always_comb begin
      mtrapcnt_d = mtrapcnt_q;
      if ((state_q == S_SAVE) && (mtrapcnt_q != 16'hFFFF)) begin
         mtrapcnt_d = mtrapcnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= S_IDLE;
         info_q           <= 32'h0;
         mstatus_q        <= MSTATUS_RESET;
         prev_mstatus_q   <= 32'h0;
         mtvec_q          <= MTVEC_RESET;
         mepc_q           <= 16'h0;
         mcause_q         <= 32'h0;
         mip_q            <= MIP_RESET;
         mtrapcnt_q       <= 16'h0;
         pc_target_q      <= 16'h0;
         flush_q          <= 1'b0;
         redirect_valid_q <= 1'b0;
      end else begin
         mtrapcnt_q <= mtrapcnt_d;

         // Software writes first; FSM updates below take priority on the
         // same register because the later non-blocking assignment wins.
         if (csr_we) begin
            case (csr_addr)
               A_MSTATUS: mstatus_q <= csr_wdata;
               A_MTVEC:   mtvec_q   <= csr_wdata;
               A_MEPC:    mepc_q    <= csr_wdata[15:0];
               A_MCAUSE:  mcause_q  <= csr_wdata;
               A_MIP:     mip_q     <= csr_wdata;
               default:   ;
            endcase
         end

         case (state_q)
            S_IDLE: begin
               if (trap_take) begin
                  // An exception keeps its own cause_type; a lone interrupt forces 1.
                  info_q  <= {(exception ? excep_info[31] : 1'b1), excep_info[30:0]};
                  flush_q <= 1'b1;
                  state_q <= S_SAVE;
               end
            end
            S_SAVE: begin
               mepc_q           <= info_q[15:0];
               mcause_q         <= {info_q[31], 24'h0, info_q[30:24]};
               prev_mstatus_q   <= mstatus_q;
               mstatus_q        <= {24'h0, info_q[23:16]};
               pc_target_q      <= mtvec_q[15:0];
               flush_q          <= 1'b0;
               redirect_valid_q <= 1'b1;
               state_q          <= S_ENTER;
            end
            S_ENTER: begin
               if (redirect_ready) begin
                  redirect_valid_q <= 1'b0;
                  state_q          <= S_HANDLER;
               end
            end
            S_HANDLER: begin
               // No nesting: trap requests are ignored while the handler runs.
               if (mret_instr) begin
                  mstatus_q        <= prev_mstatus_q;
                  pc_target_q      <= mepc_q;
                  redirect_valid_q <= 1'b1;
                  state_q          <= S_RETURN;
               end
            end
            S_RETURN: begin
               if (redirect_ready) begin
                  redirect_valid_q <= 1'b0;
                  state_q          <= S_IDLE;
               end
            end
            default: begin
               flush_q          <= 1'b0;
               redirect_valid_q <= 1'b0;
               state_q          <= S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      csr_rdata = 32'h0;
      case (csr_addr)
         A_MSTATUS:  csr_rdata = mstatus_q;
         A_MTVEC:    csr_rdata = mtvec_q;
         A_MEPC:     csr_rdata = {16'h0, mepc_q};
         A_MCAUSE:   csr_rdata = mcause_q;
         A_MIP:      csr_rdata = mip_q;
         A_MTRAPCNT: csr_rdata = {16'h0, mtrapcnt_q};
         default:    csr_rdata = 32'h0;
      endcase
   end

   assign flush          = flush_q;
   assign redirect_valid = redirect_valid_q;
   assign pc_target      = pc_target_q;
   assign mstatus        = mstatus_q;
   assign mip            = mip_q;
   assign busy           = (state_q != S_IDLE);
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_trap_csr_unit.sv
// -----------------------------------------------------------------------------
// tb_trap_csr_unit
//   Directed bench for trap_csr_unit. Driver tasks advance a transaction-level
//   model of the trap CSRs and the expected handshake outputs; a compare
//   process checks the DUT against that model on every falling edge, and
//   literal expectations pin the model at key points.
// -----------------------------------------------------------------------------
module tb_trap_csr_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        exception;
   logic        interrup;
   logic [31:0] excep_info;
   logic        mret_instr;
   logic        csr_we;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        flush;
   logic        redirect_valid;
   logic        redirect_ready;
   logic [15:0] pc_target;
   logic [31:0] mstatus;
   logic [31:0] mip;
   logic        busy;
   logic [2:0]  dbg_state;

   trap_csr_unit dut (
      .clk            (clk),
      .rst            (rst),
      .exception      (exception),
      .interrup       (interrup),
      .excep_info     (excep_info),
      .mret_instr     (mret_instr),
      .csr_we         (csr_we),
      .csr_addr       (csr_addr),
      .csr_wdata      (csr_wdata),
      .csr_rdata      (csr_rdata),
      .flush          (flush),
      .redirect_valid (redirect_valid),
      .redirect_ready (redirect_ready),
      .pc_target      (pc_target),
      .mstatus        (mstatus),
      .mip            (mip),
      .busy           (busy),
      .dbg_state      (dbg_state)
   );

   // ---------------- clock ----------------
   always #10 clk = ~clk;

   // ---------------- counters ----------------
   int n_checks = 0;
   int n_fail   = 0;
   int rv_cycles = 0;
   bit check_en = 1'b0;

   // ---------------- model ----------------
   logic [31:0] m_mstatus, m_mtvec, m_mcause, m_mip, m_prev;
   logic [15:0] m_mepc, m_cnt;
   logic        e_flush, e_rv, e_busy;
   logic [15:0] e_pc;

   task automatic model_reset();
      m_mstatus = 32'h1;
      m_mtvec   = 32'h100;
      m_mip     = 32'h0;
      m_mcause  = 32'h0;
      m_prev    = 32'h0;
      m_mepc    = 16'h0;
      m_cnt     = 16'h0;
      e_flush   = 1'b0;
      e_rv      = 1'b0;
      e_busy    = 1'b0;
      e_pc      = 16'h0;
   endtask

   task automatic model_write(input logic [11:0] addr, input logic [31:0] data);
      case (addr)
         12'h300: m_mstatus = data;
         12'h305: m_mtvec   = data;
         12'h341: m_mepc    = data[15:0];
         12'h342: m_mcause  = data;
         12'h344: m_mip     = data;
         default: ;
      endcase
   endtask

   function automatic logic [31:0] model_read(input logic [11:0] addr);
      case (addr)
         12'h300: return m_mstatus;
         12'h305: return m_mtvec;
         12'h341: return {16'h0, m_mepc};
         12'h342: return m_mcause;
         12'h344: return m_mip;
         12'h7C0: return {16'h0, m_cnt};
         default: return 32'h0;
      endcase
   endfunction

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (redirect_valid) rv_cycles++;
      if (check_en) begin
         check("cyc_flush", 32'(flush), 32'(e_flush));
         check("cyc_redirect_valid", 32'(redirect_valid), 32'(e_rv));
         check("cyc_busy", 32'(busy), 32'(e_busy));
         check("cyc_mstatus", mstatus, m_mstatus);
         check("cyc_mip", mip, m_mip);
         if (e_rv) check("cyc_pc_target", 32'(pc_target), 32'(e_pc));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic read_model(input string name, input logic [11:0] addr);
      csr_addr = addr;
      #1;
      check(name, csr_rdata, model_read(addr));
   endtask

   task automatic read_lit(input string name, input logic [11:0] addr, input logic [31:0] lit);
      csr_addr = addr;
      #1;
      check(name, csr_rdata, lit);
   endtask

   task automatic write_csr(input logic [11:0] addr, input logic [31:0] data);
      csr_we = 1'b1; csr_addr = addr; csr_wdata = data;
      tick();
      csr_we = 1'b0;
      model_write(addr, data);
   endtask

   // Starts in IDLE, returns at the start of the first ENTER cycle.
   task automatic do_trap(input bit exc, input bit intr, input logic [31:0] info,
                          input bit we, input logic [11:0] addr, input logic [31:0] data);
      logic        cause;
      logic [31:0] old_mstatus;
      exception = exc; interrup = intr; excep_info = info;
      tick();
      exception = 1'b0; interrup = 1'b0;
      e_flush = 1'b1; e_busy = 1'b1;
      if (we) begin
         csr_we = 1'b1; csr_addr = addr; csr_wdata = data;
      end
      tick();
      csr_we = 1'b0;
      old_mstatus = m_mstatus;
      if (we) model_write(addr, data);
      cause     = exc ? info[31] : 1'b1;
      m_prev    = old_mstatus;
      m_mstatus = {24'h0, info[23:16]};
      m_mepc    = info[15:0];
      m_mcause  = {cause, 24'h0, info[30:24]};
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      e_flush = 1'b0; e_rv = 1'b1; e_pc = m_mtvec[15:0];
   endtask

   // Starts in HANDLER, returns at the start of the first RETURN cycle.
   task automatic mret_enter();
      mret_instr = 1'b1;
      tick();
      mret_instr = 1'b0;
      m_mstatus = m_prev;
      e_rv = 1'b1; e_pc = m_mepc;
   endtask

   task automatic handshake(input int delay, input bit to_idle);
      int start;
      start = rv_cycles;
      for (int i = 0; i < delay; i++) begin
         redirect_ready = 1'b0;
         tick();
      end
      redirect_ready = 1'b1;
      tick();
      redirect_ready = 1'b0;
      e_rv = 1'b0;
      if (to_idle) e_busy = 1'b0;
      check("rv_hold_cycles", 32'(rv_cycles - start), 32'(delay + 1));
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      exception = 1'b0; interrup = 1'b0; excep_info = 32'h0;
      mret_instr = 1'b0; csr_we = 1'b0; csr_addr = 12'h0; csr_wdata = 32'h0;
      redirect_ready = 1'b0;
      model_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      check("rst_flush", 32'(flush), 32'h0);
      check("rst_redirect_valid", 32'(redirect_valid), 32'h0);
      check("rst_pc_target", 32'(pc_target), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_dbg_state", 32'(dbg_state), 32'h0);
      check("rst_mstatus", mstatus, 32'h1);
      check("rst_mip", mip, 32'h0);
      read_lit("rst_mtvec", 12'h305, 32'h100);
      read_model("rst_mepc", 12'h341);
      read_model("rst_mcause", 12'h342);
      read_model("rst_mtrapcnt", 12'h7C0);
      rst = 1'b0;
      check_en = 1'b1;
      tick();

      // 1: exception, immediate ready
      do_trap(1'b1, 1'b0, 32'h0210_0040, 1'b0, 12'h0, 32'h0);
      check("t1_pc_target", 32'(pc_target), 32'h0100);
      read_lit("t1_mcause", 12'h342, 32'h2);
      read_lit("t1_mepc", 12'h341, 32'h40);
      read_lit("t1_mstatus", 12'h300, 32'h10);
      read_lit("t1_mtrapcnt", 12'h7C0, 32'h1);
      handshake(0, 1'b0);

      // 2: mret with ready held low 3 cycles
      mret_enter();
      check("t2_pc_target", 32'(pc_target), 32'h0040);
      handshake(3, 1'b1);
      check("t2_mstatus", mstatus, 32'h1);
      check("t2_busy", 32'(busy), 32'h0);

      // 3: nested request ignored, software-modified mepc used on return
      do_trap(1'b1, 1'b0, 32'h0310_0060, 1'b0, 12'h0, 32'h0);
      handshake(2, 1'b0);
      exception = 1'b1;
      tick();
      tick();
      exception = 1'b0;
      read_lit("t3_mtrapcnt", 12'h7C0, 32'h2);
      write_csr(12'h341, 32'h0044);
      mret_enter();
      check("t3_pc_target", 32'(pc_target), 32'h0044);
      handshake(1, 1'b1);

      // 4: interrupt gated by mip[0]
      write_csr(12'h344, 32'h1);
      do_trap(1'b0, 1'b1, 32'h0B10_0080, 1'b0, 12'h0, 32'h0);
      read_lit("t4_mcause", 12'h342, 32'h8000_000B);
      read_lit("t4_mepc", 12'h341, 32'h80);
      read_lit("t4_mtrapcnt", 12'h7C0, 32'h3);
      handshake(0, 1'b0);
      mret_enter();
      handshake(0, 1'b1);
      write_csr(12'h344, 32'h0);
      interrup = 1'b1; excep_info = 32'h0B10_0080;
      repeat (3) tick();
      interrup = 1'b0;
      check("t4_masked_busy", 32'(busy), 32'h0);
      read_lit("t4_masked_mtrapcnt", 12'h7C0, 32'h3);

      // 5: hardware update beats same-cycle mcause write; read-only counter
      do_trap(1'b1, 1'b0, 32'h0720_0090, 1'b1, 12'h342, 32'h55);
      read_lit("t5_mcause", 12'h342, 32'h7);
      handshake(0, 1'b0);
      write_csr(12'h7C0, 32'h1234);
      read_lit("t5_mtrapcnt", 12'h7C0, 32'h4);
      write_csr(12'h123, 32'hDEAD_BEEF);
      read_lit("t5_unmapped", 12'h123, 32'h0);
      mret_enter();
      handshake(0, 1'b1);
      read_model("t5_mstatus_rd", 12'h300);

      // 6a: asynchronous reset while ENTER waits for ready
      do_trap(1'b1, 1'b0, 32'h0110_00A0, 1'b0, 12'h0, 32'h0);
      redirect_ready = 1'b0;
      tick();
      #2;
      check_en = 1'b0;
      rst = 1'b1;
      #1;
      check("t6_rst_redirect_valid", 32'(redirect_valid), 32'h0);
      check("t6_rst_busy", 32'(busy), 32'h0);
      check("t6_rst_flush", 32'(flush), 32'h0);
      check("t6_rst_mstatus", mstatus, 32'h1);
      check("t6_rst_pc_target", 32'(pc_target), 32'h0);
      model_reset();
      tick();
      rst = 1'b0;
      check_en = 1'b1;
      tick();
      read_lit("t6_rst_mtrapcnt", 12'h7C0, 32'h0);

      // 6b: trap counter saturation
      force dut.mtrapcnt_d = 16'hFFFF;
      tick();
      release dut.mtrapcnt_d;
      m_cnt = 16'hFFFF;
      read_lit("t6_cnt_preset", 12'h7C0, 32'hFFFF);
      do_trap(1'b1, 1'b0, 32'h0210_0040, 1'b0, 12'h0, 32'h0);
      read_lit("t6_cnt_sat", 12'h7C0, 32'hFFFF);
      handshake(0, 1'b0);
      mret_enter();
      handshake(0, 1'b1);
      tick();
      read_lit("t6_cnt_final", 12'h7C0, 32'hFFFF);

      check_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
